// File: rtl/ps2_digit_decode_fifo_if.sv
// Byte-in / digit-event-out bundle for the PS/2 digit decoder.
// slave = decoder side, master = byte source plus digit consumer.
interface ps2_digit_decode_fifo_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    code_in;
    logic          code_valid;
    logic [3:0]    out_digit;
    logic          out_release;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          invalid;
    logic          overflow;

    modport master (
        output code_in,
        output code_valid,
        output out_ready,
        input  out_digit,
        input  out_release,
        input  out_valid,
        input  count,
        input  invalid,
        input  overflow
    );

    modport slave (
        input  code_in,
        input  code_valid,
        input  out_ready,
        output out_digit,
        output out_release,
        output out_valid,
        output count,
        output invalid,
        output overflow
    );
endinterface

// File: rtl/ps2_digit_decode_fifo.sv
// PS/2 set-2 scancode parser with digit mapping and an event FIFO.
// Tracks F0/E0 prefixes; extended keys never yield digits.
module ps2_digit_decode_fifo #(
    parameter int DEPTH      = 4,
    parameter int KEYPAD_EN  = 1,
    parameter int RELEASE_EN = 0
) (
    input logic clk,
    input logic rst_n,
    ps2_digit_decode_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        BRK,
        EXT,
        EXT_BRK
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;
    logic          invalid_q, invalid_d;
    logic          overflow_q;

    logic          map_hit;
    logic [3:0]    map_dig;
    logic          push_req, push_rel;
    logic          full, pop, push_ok, drop;

    // Scancode to digit lookup; keypad codes only when enabled.
    always_comb begin
        map_hit = 1'b1;
        map_dig = 4'd0;
        case (bus.code_in)
            8'h45: map_dig = 4'd0;
            8'h16: map_dig = 4'd1;
            8'h1E: map_dig = 4'd2;
            8'h26: map_dig = 4'd3;
            8'h25: map_dig = 4'd4;
            8'h2E: map_dig = 4'd5;
            8'h36: map_dig = 4'd6;
            8'h3D: map_dig = 4'd7;
            8'h3E: map_dig = 4'd8;
            8'h46: map_dig = 4'd9;
            default: map_hit = 1'b0;
        endcase
        if (!map_hit && KEYPAD_EN != 0) begin
            map_hit = 1'b1;
            case (bus.code_in)
                8'h70: map_dig = 4'd0;
                8'h69: map_dig = 4'd1;
                8'h72: map_dig = 4'd2;
                8'h7A: map_dig = 4'd3;
                8'h6B: map_dig = 4'd4;
                8'h73: map_dig = 4'd5;
                8'h74: map_dig = 4'd6;
                8'h6C: map_dig = 4'd7;
                8'h75: map_dig = 4'd8;
                8'h7D: map_dig = 4'd9;
                default: map_hit = 1'b0;
            endcase
        end
    end

    // Prefix parser: next state, push request and invalid flag.
    always_comb begin
        state_d   = state_q;
        push_req  = 1'b0;
        push_rel  = 1'b0;
        invalid_d = 1'b0;
        if (bus.code_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.code_in == 8'hF0) begin
                        state_d = BRK;
                    end else if (bus.code_in == 8'hE0) begin
                        state_d = EXT;
                    end else if (map_hit) begin
                        push_req = 1'b1;
                    end else if (bus.code_in != 8'hAA &&
                                 bus.code_in != 8'hFA) begin
                        invalid_d = 1'b1;
                    end
                end
                BRK: begin
                    state_d = IDLE;
                    if (map_hit && RELEASE_EN != 0) begin
                        push_req = 1'b1;
                        push_rel = 1'b1;
                    end
                end
                EXT: begin
                    state_d = (bus.code_in == 8'hF0) ? EXT_BRK : IDLE;
                end
                EXT_BRK: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign full    = (count_q == CW'(DEPTH));
    assign pop     = (count_q != '0) && bus.out_ready;
    assign push_ok = push_req && (!full || pop);
    assign drop    = push_req && full && !pop;

    // Parser state, FIFO storage, pointers and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            invalid_q  <= 1'b0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            invalid_q <= invalid_d;
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (push_ok) begin
                mem_q[wr_q] <= {push_rel, map_dig};
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            count_q <= count_q + CW'(push_ok) - CW'(pop);
        end
    end

    assign bus.out_digit   = mem_q[rd_q][3:0];
    assign bus.out_release = mem_q[rd_q][4];
    assign bus.out_valid   = (count_q != '0);
    assign bus.count       = count_q;
    assign bus.invalid     = invalid_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_ps2_digit_decode_fifo.sv
// Bench for ps2_digit_decode_fifo: two parameter sets driven in
// lockstep, checked against a scancode reference model.
module tb_ps2_digit_decode_fifo;
    localparam int DEPTH = 4;
    localparam int NT    = 23;

    typedef struct {
        logic [7:0] code;
        int         main_d;
        int         kp_d;
    } map_t;

    logic clk;
    logic rst_n;

    ps2_digit_decode_fifo_if #(.DEPTH(DEPTH)) ifa ();
    ps2_digit_decode_fifo_if #(.DEPTH(DEPTH)) ifb ();

    ps2_digit_decode_fifo #(
        .DEPTH(DEPTH), .KEYPAD_EN(1), .RELEASE_EN(0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );

    ps2_digit_decode_fifo #(
        .DEPTH(DEPTH), .KEYPAD_EN(0), .RELEASE_EN(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    map_t       tbl [NT];
    int         kp_en  [2] = '{1, 0};
    int         rel_en [2] = '{0, 1};
    int         st  [2];
    int         cnt [2];
    bit         inv [2];
    bit         ovf [2];
    logic [4:0] qa [$];
    logic [4:0] qb [$];
    int         total;
    int         bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lookup(logic [7:0] c, int kp);
        for (int i = 0; i < NT; i++) begin
            if (tbl[i].code == c) begin
                if (tbl[i].main_d >= 0) return tbl[i].main_d;
                if (kp != 0) return tbl[i].kp_d;
                return -1;
            end
        end
        return -1;
    endfunction

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic model(int d, logic v, logic [7:0] b, logic rdy);
        int         m;
        bit         push;
        bit         rel;
        bit         pop;
        logic [4:0] head;
        logic [4:0] got;
        logic [4:0] e;
        pop = rdy && (cnt[d] > 0);
        if (pop) begin
            if (d == 0) begin
                head = qa.pop_front();
                got  = {ifa.out_release, ifa.out_digit};
                chk("a_valid_at_pop", int'(ifa.out_valid), 1);
            end else begin
                head = qb.pop_front();
                got  = {ifb.out_release, ifb.out_digit};
                chk("b_valid_at_pop", int'(ifb.out_valid), 1);
            end
            chk($sformatf("head%0d", d), int'(got), int'(head));
        end
        push   = 1'b0;
        rel    = 1'b0;
        inv[d] = 1'b0;
        m      = -1;
        if (v) begin
            m = lookup(b, kp_en[d]);
            case (st[d])
                0: begin
                    if (b == 8'hF0) st[d] = 1;
                    else if (b == 8'hE0) st[d] = 2;
                    else if (m >= 0) push = 1'b1;
                    else if (b != 8'hAA && b != 8'hFA) inv[d] = 1'b1;
                end
                1: begin
                    st[d] = 0;
                    if (m >= 0 && rel_en[d] != 0) begin
                        push = 1'b1;
                        rel  = 1'b1;
                    end
                end
                2: st[d] = (b == 8'hF0) ? 3 : 0;
                default: st[d] = 0;
            endcase
        end
        if (push) begin
            if (cnt[d] < DEPTH || pop) begin
                e = {rel, 4'(m)};
                if (d == 0) qa.push_back(e);
                else qb.push_back(e);
                cnt[d]++;
            end else begin
                ovf[d] = 1'b1;
            end
        end
        if (pop) cnt[d]--;
    endtask

    task automatic post();
        chk("a_count", int'(ifa.count), cnt[0]);
        chk("a_valid", int'(ifa.out_valid), int'(cnt[0] > 0));
        chk("a_invalid", int'(ifa.invalid), int'(inv[0]));
        chk("a_overflow", int'(ifa.overflow), int'(ovf[0]));
        chk("b_count", int'(ifb.count), cnt[1]);
        chk("b_valid", int'(ifb.out_valid), int'(cnt[1] > 0));
        chk("b_invalid", int'(ifb.invalid), int'(inv[1]));
        chk("b_overflow", int'(ifb.overflow), int'(ovf[1]));
    endtask

    // Called at a falling edge; leaves the bench at the next one.
    task automatic step(logic v, logic [7:0] b, logic rdy);
        ifa.code_valid = v;
        ifa.code_in    = b;
        ifa.out_ready  = rdy;
        ifb.code_valid = v;
        ifb.code_in    = b;
        ifb.out_ready  = rdy;
        model(0, v, b, rdy);
        model(1, v, b, rdy);
        @(negedge clk);
        ifa.code_valid = 1'b0;
        ifa.out_ready  = 1'b0;
        ifb.code_valid = 1'b0;
        ifb.out_ready  = 1'b0;
        post();
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((cnt[0] > 0 || cnt[1] > 0) && guard < 4 * DEPTH) begin
            step(1'b0, 8'h00, 1'b1);
            guard++;
        end
        chk("drain_bound", guard < 4 * DEPTH ? 1 : 0, 1);
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            st[d]  = 0;
            cnt[d] = 0;
            inv[d] = 1'b0;
            ovf[d] = 1'b0;
        end
        qa.delete();
        qb.delete();
        #2;
        post();
        chk("a_rst_digit", int'(ifa.out_digit), 0);
        chk("a_rst_release", int'(ifa.out_release), 0);
        chk("b_rst_digit", int'(ifb.out_digit), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send(logic [7:0] b);
        step(1'b1, b, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{8'h45, 0, -1};
        tbl[1]  = '{8'h16, 1, -1};
        tbl[2]  = '{8'h1E, 2, -1};
        tbl[3]  = '{8'h26, 3, -1};
        tbl[4]  = '{8'h25, 4, -1};
        tbl[5]  = '{8'h2E, 5, -1};
        tbl[6]  = '{8'h36, 6, -1};
        tbl[7]  = '{8'h3D, 7, -1};
        tbl[8]  = '{8'h3E, 8, -1};
        tbl[9]  = '{8'h46, 9, -1};
        tbl[10] = '{8'h70, -1, 0};
        tbl[11] = '{8'h69, -1, 1};
        tbl[12] = '{8'h72, -1, 2};
        tbl[13] = '{8'h7A, -1, 3};
        tbl[14] = '{8'h6B, -1, 4};
        tbl[15] = '{8'h73, -1, 5};
        tbl[16] = '{8'h74, -1, 6};
        tbl[17] = '{8'h6C, -1, 7};
        tbl[18] = '{8'h75, -1, 8};
        tbl[19] = '{8'h7D, -1, 9};
        tbl[20] = '{8'h1C, -1, -1};
        tbl[21] = '{8'h5A, -1, -1};
        tbl[22] = '{8'h00, -1, -1};

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        ifa.code_in = '0; ifa.code_valid = 1'b0; ifa.out_ready = 1'b0;
        ifb.code_in = '0; ifb.code_valid = 1'b0; ifb.out_ready = 1'b0;
        @(negedge clk);
        do_reset();

        send(8'h16); send(8'h1E); send(8'h46);
        drain();

        for (int i = 0; i < NT; i++) begin
            send(tbl[i].code);
            send(8'hF0);
            send(tbl[i].code);
            step(1'b0, 8'h00, 1'b0);
            drain();
        end

        send(8'h26); send(8'hF0); send(8'h26);
        drain();

        send(8'hE0); send(8'h70);
        send(8'hE0); send(8'hF0); send(8'h70);
        send(8'hAA); send(8'hFA);
        send(8'hF0); send(8'hF0); send(8'h16);
        send(8'hF0); send(8'hE0); send(8'h1E);
        send(8'hE0); send(8'hE0); send(8'h25);
        drain();

        send(8'h16); send(8'h1E); send(8'h26);
        send(8'h25); send(8'h2E);
        step(1'b1, 8'h36, 1'b1);
        step(1'b1, 8'h3D, 1'b1);
        drain();
        step(1'b1, 8'h45, 1'b1);
        step(1'b1, 8'h46, 1'b0);
        drain();

        do_reset();
        send(8'h16); send(8'h1E); send(8'h46);
        send(8'hF0);
        do_reset();
        send(8'h45);
        chk("a_post_rst_count", int'(ifa.count), 1);
        chk("a_post_rst_digit", int'(ifa.out_digit), 0);
        drain();

        send(8'hE0);
        do_reset();
        send(8'h3E);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
